hand_datapath: RTL

//  Baccarat card datapath that feeds the per-card 7-segment decoders.
//  A free-running counter generates card codes 1..13. Six 4-bit hand registers
//  (player 1-3, dealer 1-3) capture the current code on one-hot load strobes

---
 rtl/hand_datapath.sv | 102 ++++++++++
 1 files changed

// File: rtl/hand_datapath.sv
// Baccarat hand datapath: card generator, six hand registers, registered scores and counts.
// Latency: a card loads 1 cycle after its strobe; scores and counts follow 1 cycle later. No backpressure.
module hand_datapath #(
  parameter int CARD_MAX = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_round,
  input  logic [2:0] load_p,
  input  logic [2:0] load_d,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [1:0] pcount,
  output logic [1:0] dcount
);

  localparam logic [3:0] GEN_LAST = 4'(CARD_MAX);

  logic [3:0] gen;
  logic [4:0] psum;
  logic [4:0] dsum;
  logic       clear;

  // Baccarat values: only A..9 count, tens and court cards are worth nothing.
  function automatic logic [4:0] card_value(input logic [3:0] code);
    if (code >= 4'd1 && code <= 4'd9) begin
      return {1'b0, code};
    end
    return 5'd0;
  endfunction

  function automatic logic [3:0] mod10(input logic [4:0] sum);
    logic [4:0] r;
    r = sum;
    if (r >= 5'd20) begin
      r = r - 5'd20;
    end else if (r >= 5'd10) begin
      r = r - 5'd10;
    end
    return r[3:0];
  endfunction

  function automatic logic [1:0] filled(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c);
    return 2'(a != 4'd0) + 2'(b != 4'd0) + 2'(c != 4'd0);
  endfunction

  assign clear = reset | new_round;
  assign psum  = card_value(pcard1) + card_value(pcard2) + card_value(pcard3);
  assign dsum  = card_value(dcard1) + card_value(dcard2) + card_value(dcard3);

  // Free-running deck position; never touched by new_round.
  always_ff @(posedge clk) begin
    if (reset) begin
      gen <= 4'd1;
    end else if (gen == GEN_LAST) begin
      gen <= 4'd1;
    end else begin
      gen <= gen + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      pcard1 <= 4'd0;
      pcard2 <= 4'd0;
      pcard3 <= 4'd0;
      dcard1 <= 4'd0;
      dcard2 <= 4'd0;
      dcard3 <= 4'd0;
    end else begin
      if (load_p[0]) pcard1 <= gen;
      if (load_p[1]) pcard2 <= gen;
      if (load_p[2]) pcard3 <= gen;
      if (load_d[0]) dcard1 <= gen;
      if (load_d[1]) dcard2 <= gen;
      if (load_d[2]) dcard3 <= gen;
    end
  end

  // Scores and counts are taken from the card registers, one cycle behind them.
  always_ff @(posedge clk) begin
    if (clear) begin
      pscore <= 4'd0;
      dscore <= 4'd0;
      pcount <= 2'd0;
      dcount <= 2'd0;
    end else begin
      pscore <= mod10(psum);
      dscore <= mod10(dsum);
      pcount <= filled(pcard1, pcard2, pcard3);
      dcount <= filled(dcard1, dcard2, dcard3);
    end
  end

endmodule
